// File: rtl/camera_seq.sv
// camera_seq: camera power-up/power-down sequencer and camera master-clock
// divider.
//
// The divider turns the system clock into the camera clock. The block drives
// the sensor power-down and reset pins in the required order, and tells the
// capture logic when the sensor may be configured.
//
// Optional build macro: CAMSEQ_WATCHDOG_EN. When it is defined, a missing
// vsync while READY sets the sticky `fault` output and powers the sensor down.
// When it is undefined, `vsync` is unused and `fault` is tied to 0.
//
// Ports:
//   clk         in  system clock (40 MHz)
//   rst         in  synchronous active-high reset
//   start       in  power-up request (single-cycle pulse)
//   stop        in  power-down request (single-cycle pulse; wins over start)
//   vsync       in  frame sync, already in the clk domain (watchdog only)
//   clkCameraSS out camera master clock, clk / (2*DIV_HALF), 50% duty
//   camPwdn     out sensor power-down, 1 = powered down
//   camRstN     out sensor reset, active low
//   ready       out sensor powered, clocked and out of reset
//   busy        out sequencing in progress
//   fault       out sticky watchdog fault
module camera_seq #(
  parameter int DIV_HALF   = 1,
  parameter int T_PWR      = 400,
  parameter int T_RST      = 800,
  parameter int T_SETTLE   = 1000,
  parameter int CNT_W      = 16,
  parameter int WDOG_TICKS = 4000000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic vsync,
  output logic clkCameraSS,
  output logic camPwdn,
  output logic camRstN,
  output logic ready,
  output logic busy,
  output logic fault
);

  typedef enum logic [2:0] {
    OFF, PWRUP, CLKUP, RSTREL, READY, PWRDN, CLKSTOP
  } state_t;

  localparam logic [CNT_W-1:0] LD_PWR    = CNT_W'(T_PWR - 1);
  localparam logic [CNT_W-1:0] LD_RST    = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(T_SETTLE - 1);
  localparam logic [7:0]       DIV_LAST  = 8'(DIV_HALF - 1);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, ld_val;
  logic             ld;
  logic [7:0]       div_cnt;
  logic             clk_en;
  logic             gate;
  logic             wd_trip;

`ifdef CAMSEQ_WATCHDOG_EN
  // The frame watchdog counts READY cycles since the last vsync rising edge.
  // A rising edge wins over a trip in the same cycle.
  logic        vsync_d;
  logic        vs_rise;
  logic [31:0] wd_cnt;

  assign vs_rise = vsync && !vsync_d;
  assign wd_trip = (state == READY) && !vs_rise && (wd_cnt == 32'(WDOG_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d <= 1'b0;
      wd_cnt  <= '0;
      fault   <= 1'b0;
    end else begin
      vsync_d <= vsync;
      if (state != READY || vs_rise) wd_cnt <= '0;
      else                           wd_cnt <= wd_cnt + 32'd1;
      if (wd_trip)                              fault <= 1'b1;
      else if (state == OFF && nxt == PWRUP)    fault <= 1'b0;
    end
  end
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign wd_trip      = 1'b0;
  assign fault        = 1'b0;
`endif

  // The clock may only be gated on a low phase. This means a high phase is
  // never truncated, except by rst.
  assign gate = (state == CLKSTOP) && !clkCameraSS;

  always_comb begin
    nxt    = state;
    ld     = 1'b0;
    ld_val = '0;
    unique case (state)
      OFF: if (start && !stop) begin
        nxt = PWRUP; ld = 1'b1; ld_val = LD_PWR;
      end
      PWRUP: if (stop) begin
        nxt = PWRDN; ld = 1'b1; ld_val = LD_RST;
      end else if (cnt == '0) begin
        nxt = CLKUP; ld = 1'b1; ld_val = LD_RST;
      end
      CLKUP: if (stop) begin
        nxt = PWRDN; ld = 1'b1; ld_val = LD_RST;
      end else if (cnt == '0) begin
        nxt = RSTREL; ld = 1'b1; ld_val = LD_SETTLE;
      end
      RSTREL: if (stop) begin
        nxt = PWRDN; ld = 1'b1; ld_val = LD_RST;
      end else if (cnt == '0) begin
        nxt = READY;
      end
      READY: if (stop || wd_trip) begin
        nxt = PWRDN; ld = 1'b1; ld_val = LD_RST;
      end
      PWRDN: if (cnt == '0) nxt = CLKSTOP;
      CLKSTOP: if (gate) nxt = OFF;
      default: nxt = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= OFF;
      cnt         <= '0;
      div_cnt     <= '0;
      clk_en      <= 1'b0;
      clkCameraSS <= 1'b0;
      camPwdn     <= 1'b1;
      camRstN     <= 1'b0;
      ready       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state <= nxt;
      if (ld)              cnt <= ld_val;
      else if (cnt != '0)  cnt <= cnt - 1'b1;

      // The enable is only raised on the normal PWRUP->CLKUP path. A stop
      // during PWRUP powers the sensor down without ever clocking it.
      if (state == PWRUP && nxt == CLKUP) clk_en <= 1'b1;
      else if (gate)                      clk_en <= 1'b0;

      if (!clk_en || gate) begin
        div_cnt     <= '0;
        clkCameraSS <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt     <= '0;
        clkCameraSS <= ~clkCameraSS;
      end else begin
        div_cnt     <= div_cnt + 8'd1;
      end

      // The pin outputs are registered from the next state, so they line up
      // with the state register.
      camPwdn <= (nxt == OFF);
      camRstN <= (nxt == RSTREL) || (nxt == READY);
      ready   <= (nxt == READY);
      busy    <= !((nxt == OFF) || (nxt == READY));
    end
  end

endmodule
